// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the decode/exception logic and the pc sequencer.
interface pc_sequencer_if;
    logic        stall_i;
    logic        br_valid_i;
    logic [31:0] br_target_i;
    logic        exc_req_i;
    logic        eret_req_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic        fetch_valid_o;
    logic [3:0]  fetch_err_o;
    logic        pend_valid_o;

    modport master (
        output stall_i, br_valid_i, br_target_i, exc_req_i, eret_req_i, epc_i,
        input  pc_o, pc4_o, fetch_valid_o, fetch_err_o, pend_valid_o
    );

    modport slave (
        input  stall_i, br_valid_i, br_target_i, exc_req_i, eret_req_i, epc_i,
        output pc_o, pc4_o, fetch_valid_o, fetch_err_o, pend_valid_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction fetch pc sequencer with stall, pending-redirect, exception and eret handling.
// Optional macro PC_RANGE_CHECK_EN enables alignment/window checking of the fetch address.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_4ffc
) (
    input  logic          clk_i,
    input  logic          reset_i,   // asynchronous, active low
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_PEND = 2'd2
    } state_e;

`ifdef PC_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif

    localparam logic [3:0] ERR_ADEL = 4'd4;

    function automatic logic pc_legal(input logic [31:0] addr);
        pc_legal = (addr[1:0] == 2'b00) && (addr >= IM_LO) && (addr <= IM_HI);
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] pc_inc_s;
    logic        legal_s;

    assign pc_inc_s = pc_q + 32'd4;
    assign legal_s  = pc_legal(pc_q);

    // State, pc and pending-target registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // Next-pc selection: exception, eret, pending release, branch, stall, sequential
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        if (bus.exc_req_i) begin
            state_d = ST_RUN;
            pc_d    = HANDLER_PC;
            pend_d  = 32'h0000_0000;
        end else if (bus.eret_req_i) begin
            state_d = ST_RUN;
            pc_d    = bus.epc_i;
            pend_d  = 32'h0000_0000;
        end else begin
            case (state_q)
                ST_PEND: begin
                    if (bus.stall_i) begin
                        state_d = ST_PEND;
                        pend_d  = bus.br_valid_i ? bus.br_target_i : pend_q;
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = bus.br_valid_i ? bus.br_target_i : pend_q;
                        pend_d  = 32'h0000_0000;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (bus.stall_i) begin
                        if (bus.br_valid_i) begin
                            state_d = ST_PEND;
                            pend_d  = bus.br_target_i;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = bus.br_valid_i ? bus.br_target_i : pc_inc_s;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    pend_d  = 32'h0000_0000;
                end
            endcase
        end
    end

    // An illegal pc only flags the fetch; sequencing carries on and the exception comes back via exc_req
    assign bus.pc_o          = pc_q;
    assign bus.pc4_o         = pc_inc_s;
    assign bus.pend_valid_o  = (state_q == ST_PEND);
    assign bus.fetch_valid_o = RANGE_EN ? legal_s : 1'b1;
    assign bus.fetch_err_o   = (RANGE_EN && !legal_s) ? ERR_ADEL : 4'd0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: expected pc/pending state queued per step, compared after each edge.
module tb_pc_sequencer;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        string       tag;
    } exp_t;

    exp_t sb[$];

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_fv(input logic [31:0] a);
`ifdef PC_RANGE_CHECK_EN
        exp_fv = (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_4ffc);
`else
        exp_fv = 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Pop the oldest expectation and compare every output against it
    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check({e.tag, ".pc"}, bus.pc_o, e.pc);
            check({e.tag, ".pc4"}, bus.pc4_o, e.pc + 32'd4);
            check({e.tag, ".pend"}, {31'd0, bus.pend_valid_o}, {31'd0, e.pend});
            check({e.tag, ".fv"}, {31'd0, bus.fetch_valid_o}, {31'd0, exp_fv(e.pc)});
            check({e.tag, ".err"}, {28'd0, bus.fetch_err_o}, exp_fv(e.pc) ? 32'd0 : 32'd4);
        end
    endtask

    task automatic step(input string tag, input logic st, input logic br, input logic [31:0] tgt,
                        input logic ex, input logic er, input logic [31:0] ep,
                        input logic [31:0] exp_pc, input logic exp_pend);
        bus.stall_i     = st;
        bus.br_valid_i  = br;
        bus.br_target_i = tgt;
        bus.exc_req_i   = ex;
        bus.eret_req_i  = er;
        bus.epc_i       = ep;
        sb.push_back('{pc: exp_pc, pend: exp_pend, tag: tag});
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        bus.stall_i = 1'b0; bus.br_valid_i = 1'b0; bus.br_target_i = 32'd0;
        bus.exc_req_i = 1'b0; bus.eret_req_i = 1'b0; bus.epc_i = 32'd0;

        #12;
        sb.push_back('{pc: 32'h0000_3000, pend: 1'b0, tag: "reset"});
        compare_out();
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Sequential fetch from RESET_PC (first edge after release already taken)
        sb.push_back('{pc: 32'h0000_3004, pend: 1'b0, tag: "seq1"});
        compare_out();
        step("seq2", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_3008, 1'b0);
        step("seq3", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_300c, 1'b0);
        step("seq4", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_3010, 1'b0);

        // Redirect latched while stalled, released when stall drops
        step("pend_lat", 1'b1, 1'b1, 32'h0000_3400, 1'b0, 1'b0, 32'd0, 32'h0000_3010, 1'b1);
        step("pend_h1",  1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 32'd0, 32'h0000_3010, 1'b1);
        step("pend_h2",  1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 32'd0, 32'h0000_3010, 1'b1);
        step("pend_rel", 1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 32'd0, 32'h0000_3400, 1'b0);

        // Exception beats stall; eret returns to epc
        step("br3010",   1'b0, 1'b1, 32'h0000_3010, 1'b0, 1'b0, 32'd0,         32'h0000_3010, 1'b0);
        step("exc_stl",  1'b1, 1'b0, 32'd0,         1'b1, 1'b0, 32'd0,         32'h0000_4180, 1'b0);
        step("eret",     1'b0, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_3020, 32'h0000_3020, 1'b0);

        // HOLD then resume sequentially
        step("hold1",    1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_3020, 1'b0);
        step("hold2",    1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_3020, 1'b0);
        step("hold_rel", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_3024, 1'b0);

        // HOLD -> PEND, newest pending target wins
        step("hp_hold",  1'b1, 1'b0, 32'd0,         1'b0, 1'b0, 32'd0, 32'h0000_3024, 1'b0);
        step("hp_pend",  1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 32'd0, 32'h0000_3024, 1'b1);
        step("newest",   1'b1, 1'b1, 32'h0000_3300, 1'b0, 1'b0, 32'd0, 32'h0000_3024, 1'b1);
        step("new_rel",  1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 32'd0, 32'h0000_3300, 1'b0);

        // Branch on release overrides the pending target
        step("ov_pend",  1'b1, 1'b1, 32'h0000_3600, 1'b0, 1'b0, 32'd0, 32'h0000_3300, 1'b1);
        step("ov_rel",   1'b0, 1'b1, 32'h0000_3500, 1'b0, 1'b0, 32'd0, 32'h0000_3500, 1'b0);

        // Exception outranks eret; eret in PEND clears pending
        step("exc_eret", 1'b0, 1'b0, 32'd0,         1'b1, 1'b1, 32'h0000_3020, 32'h0000_4180, 1'b0);
        step("ep_pend",  1'b1, 1'b1, 32'h0000_3700, 1'b0, 1'b0, 32'd0,         32'h0000_4180, 1'b1);
        step("ep_eret",  1'b1, 1'b0, 32'd0,         1'b0, 1'b1, 32'h0000_3040, 32'h0000_3040, 1'b0);

        // Fetch window / alignment boundaries
        step("mis3002",  1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'd0, 32'h0000_3002, 1'b0);
        step("lo_m4",    1'b0, 1'b1, 32'h0000_2ffc, 1'b0, 1'b0, 32'd0, 32'h0000_2ffc, 1'b0);
        step("hi4ffc",   1'b0, 1'b1, 32'h0000_4ffc, 1'b0, 1'b0, 32'd0, 32'h0000_4ffc, 1'b0);
        step("seq5000",  1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 32'd0, 32'h0000_5000, 1'b0);
        step("br5000",   1'b0, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 32'd0, 32'h0000_5000, 1'b0);

        // 32-bit wrap of pc+4
        step("br_top",   1'b0, 1'b1, 32'hffff_fffc, 1'b0, 1'b0, 32'd0, 32'hffff_fffc, 1'b0);
        step("wrap",     1'b0, 1'b0, 32'd0,         1'b0, 1'b0, 32'd0, 32'h0000_0000, 1'b0);

        // Reset between edges while PEND discards the latched target
        step("r_br",     1'b0, 1'b1, 32'h0000_3010, 1'b0, 1'b0, 32'd0, 32'h0000_3010, 1'b0);
        step("r_pend",   1'b1, 1'b1, 32'h0000_3400, 1'b0, 1'b0, 32'd0, 32'h0000_3010, 1'b1);
        bus.stall_i = 1'b0; bus.br_valid_i = 1'b0; bus.br_target_i = 32'd0;
        #2 reset = 1'b0;
        #1;
        sb.push_back('{pc: 32'h0000_3000, pend: 1'b0, tag: "async_rst"});
        compare_out();
        #1 reset = 1'b1;
        step("post_rst", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_3004, 1'b0);

        total++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, first fetch address after reset.
REQ-002 Parameter HANDLER_PC, default 32'h00004180, exception handler entry.
REQ-003 Parameters IM_LO/IM_HI, defaults 32'h00003000/32'h00004ffc, legal fetch window, inclusive.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  hazard stall from decode: hold fetch.
REQ-007 br_valid  input  1  branch/jump redirect request.
REQ-008 br_target  input  32  redirect address.
REQ-009 exc_req  input  1  exception taken, flush to HANDLER_PC.
REQ-010 eret_req  input  1  return from exception to epc.
REQ-011 epc  input  32  exception return address.
REQ-012 pc  output  32  current fetch address driven to instruction memory.
REQ-013 pc4  output  32  pc + 4.
REQ-014 fetch_valid  output  1  1 = fetch at pc is legal; 0 = bubble, IM output replaced by 32'h00000000.
REQ-015 fetch_err  output  4  4 (AdEL) on illegal fetch, else 0.
REQ-016 pend_valid  output  1  redirect latched while stalled.

Function
REQ-017 FSM states: RUN, HOLD, PEND; encoding free.
REQ-018 Next-pc priority on each edge: exc_req > eret_req > PEND release > br_valid > stall > pc+4.
REQ-019 exc_req=1: pc <= HANDLER_PC, pending cleared, state <= RUN, regardless of stall.
REQ-020 eret_req=1 (exc_req=0): pc <= epc, pending cleared, state <= RUN, regardless of stall.
REQ-021 RUN, stall=0: pc <= br_valid ? br_target : pc+4; stay RUN.
REQ-022 RUN, stall=1, br_valid=0: pc held; state <= HOLD.
REQ-023 RUN/HOLD, stall=1, br_valid=1: pc held; br_target latched into pending register; state <= PEND.
REQ-024 HOLD, stall=0: same as RUN with stall=0; state <= RUN.
REQ-025 PEND, stall=1: pc held; new br_valid overwrites pending target (newest wins).
REQ-026 PEND, stall=0: pc <= br_valid ? br_target : pending target; pending cleared; state <= RUN.
REQ-027 pc+4 is 32-bit modulo: 32'hfffffffc + 4 = 32'h00000000; no saturation.
REQ-028 pc4 = pc + 4, combinational from registered pc, same wrap rule.
REQ-029 fetch_valid/fetch_err are combinational from registered pc: same-cycle as pc.
REQ-030 pend_valid = 1 exactly in state PEND.
REQ-031 Illegal pc never stalls the sequencer; sequencing continues, exception is downstream's job via exc_req.

Reset
REQ-032 reset=0 asynchronously forces pc=RESET_PC, state=RUN, pending target=0, pend_valid=0.
REQ-033 Reset-state outputs: pc=32'h00003000, pc4=32'h00003004, fetch_valid=1, fetch_err=0.
REQ-034 Reset asserted mid-PEND discards latched target; first edge after release advances from RESET_PC per REQ-018.

Configuration
REQ-035 Macro PC_RANGE_CHECK_EN defined: fetch_valid=0, fetch_err=4 when pc[1:0]!=0, pc<IM_LO or pc>IM_HI; otherwise fetch_valid=1, fetch_err=0.
REQ-036 Macro PC_RANGE_CHECK_EN undefined: no check; fetch_valid tied 1, fetch_err tied 0.

Verification
REQ-037 Release reset, no requests, 3 edges -> pc 3000, 3004, 3008, 300c; fetch_err=0.
REQ-038 pc=3010, stall=1 with br_valid=1 br_target=3400 for 1 cycle, stall 2 more cycles -> pc stays 3010, pend_valid=1; stall drop -> pc=3400, pend_valid=0.
REQ-039 pc=3010, stall=1 and exc_req=1 same cycle -> next pc=4180, state RUN; with eret_req=1 epc=3020 only -> next pc=3020.
REQ-040 PC_RANGE_CHECK_EN defined, br_target=3002 -> pc=3002, fetch_valid=0, fetch_err=4; br_target=5000 -> fetch_err=4; br_target=4ffc -> fetch_err=0.
REQ-041 PC_RANGE_CHECK_EN undefined, br_target=5000 -> fetch_valid=1, fetch_err=0.
REQ-042 In PEND (target 3400), assert reset=0 between edges -> pc=3000 immediately, pend_valid=0; after release, next edge pc=3004.
